// File: rtl/systolic_pe_mac_pkg.sv
// Shared types and arithmetic helpers for the systolic PE array.
// sat_add works on a wide container; only the low `width` bits are meaningful.
package systolic_pkg;

  localparam int PE_LAT   = 1;
  localparam int SAT_MAXW = 128;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic [SAT_MAXW-1:0] sum;
    logic                overflow;
  } sat_sum_t;

  function automatic sat_sum_t sat_add(
      input logic [SAT_MAXW-1:0] a,
      input logic [SAT_MAXW-1:0] b,
      input int                  width,
      input logic                signed_mode,
      input logic                saturate);
    logic [SAT_MAXW-1:0] mask;
    logic [SAT_MAXW-1:0] sign_bit;
    logic [SAT_MAXW:0]   raw;
    logic [SAT_MAXW-1:0] wrapped;
    logic                a_neg;
    logic                b_neg;
    logic                s_neg;
    logic                ovf;
    sat_sum_t            res;
    mask     = {SAT_MAXW{1'b1}} >> (SAT_MAXW - width);
    sign_bit = SAT_MAXW'(1) << (width - 1);
    raw      = {1'b0, a & mask} + {1'b0, b & mask};
    wrapped  = raw[SAT_MAXW-1:0] & mask;
    a_neg    = |(a & sign_bit);
    b_neg    = |(b & sign_bit);
    s_neg    = |(wrapped & sign_bit);
    // signed: like-signed operands producing an opposite-signed sum; unsigned: carry out
    if (signed_mode) begin
      ovf = (a_neg == b_neg) && (s_neg != a_neg);
    end else begin
      ovf = |(raw & ((SAT_MAXW+1)'(1) << width));
    end
    res.overflow = ovf;
    if (ovf && saturate) begin
      if (!signed_mode) begin
        res.sum = mask;
      end else if (a_neg) begin
        res.sum = sign_bit;
      end else begin
        res.sum = mask >> 1;
      end
    end else begin
      res.sum = wrapped;
    end
    return res;
  endfunction

endpackage

// File: rtl/systolic_pe_mac_if.sv
// Operand forwarding, drain chain and status signals of one PE.
// slave is the PE side, master is the neighbour/environment side.
interface systolic_pe_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
);
  logic [DATA_WIDTH-1:0] a_in;
  logic                  a_valid_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  b_valid_in;
  logic [DATA_WIDTH-1:0] a_out;
  logic                  a_valid_out;
  logic [DATA_WIDTH-1:0] b_out;
  logic                  b_valid_out;
  logic [ACC_WIDTH-1:0]  res_in;
  logic                  res_sat_in;
  logic                  res_valid_in;
  logic                  res_ready_out;
  logic [ACC_WIDTH-1:0]  res_out;
  logic                  res_sat_out;
  logic                  res_valid_out;
  logic                  res_ready_in;
  logic                  err_overrun;

  modport slave (
    input  a_in, a_valid_in, b_in, b_valid_in,
    input  res_in, res_sat_in, res_valid_in, res_ready_in,
    output a_out, a_valid_out, b_out, b_valid_out,
    output res_ready_out, res_out, res_sat_out, res_valid_out, err_overrun
  );

  modport master (
    output a_in, a_valid_in, b_in, b_valid_in,
    output res_in, res_sat_in, res_valid_in, res_ready_in,
    input  a_out, a_valid_out, b_out, b_valid_out,
    input  res_ready_out, res_out, res_sat_out, res_valid_out, err_overrun
  );
endinterface

// File: rtl/systolic_pe_mac_pe_drain_slot.sv
// One-entry drain register; local results load on the edge they complete, upstream fills otherwise.
// 1-cycle latency; upstream is refused while full (unless popping) or when a local result lands.
module pe_drain_slot #(
  parameter int WIDTH = 40
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             local_vld,
  input  logic [WIDTH-1:0] local_dat,
  input  logic             local_sat,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_dat,
  input  logic             up_sat,
  output logic             up_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_sat,
  input  logic             out_rdy,
  output logic             overrun
);
  logic pop;
  logic room;

  assign pop    = out_vld & out_rdy;
  assign room   = ~out_vld | pop;
  assign up_rdy = room & ~local_vld;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_sat <= 1'b0;
      overrun <= 1'b0;
    end else if (local_vld) begin
      // a local result that finds the slot occupied is lost; only reset clears the flag
      if (room) begin
        out_vld <= 1'b1;
        out_dat <= local_dat;
        out_sat <= local_sat;
      end else begin
        overrun <= 1'b1;
      end
    end else if (up_vld && up_rdy) begin
      out_vld <= 1'b1;
      out_dat <= up_dat;
      out_sat <= up_sat;
    end else if (pop) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/systolic_pe_mac.sv
// Output-stationary systolic PE: forwards a east / b south, accumulates K_DEPTH products.
// Operands 1-cycle pass-through, never stall; results drain via valid/ready slot with local priority.
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_DEPTH    = 8,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input logic              clock,
  input logic              nreset,
  systolic_pe_mac_if.slave pe
);
  localparam int              CNT_W    = $clog2(K_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_DEPTH - 1);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_chk
    $error("systolic_pe_mac: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end
  if (ACC_WIDTH >= SAT_MAXW) begin : g_acc_max_chk
    $error("systolic_pe_mac: ACC_WIDTH exceeds sat_add container");
  end
  if (K_DEPTH < 1) begin : g_depth_chk
    $error("systolic_pe_mac: K_DEPTH must be >= 1");
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pe.a_out       <= '0;
      pe.a_valid_out <= 1'b0;
      pe.b_out       <= '0;
      pe.b_valid_out <= 1'b0;
    end else begin
      pe.a_out       <= pe.a_in;
      pe.a_valid_out <= pe.a_valid_in;
      pe.b_out       <= pe.b_in;
      pe.b_valid_out <= pe.b_valid_in;
    end
  end

  logic                 mac_fire;
  logic [ACC_WIDTH-1:0] prod_ext;

  assign mac_fire = pe.a_valid_in & pe.b_valid_in;

  if (SIGNED != 0) begin : g_sprod
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    assign prod_s = $signed({{DATA_WIDTH{pe.a_in[DATA_WIDTH-1]}}, pe.a_in})
                  * $signed({{DATA_WIDTH{pe.b_in[DATA_WIDTH-1]}}, pe.b_in});
    assign prod_ext = ACC_WIDTH'(prod_s);
  end else begin : g_uprod
    logic [2*DATA_WIDTH-1:0] prod_u;
    assign prod_u   = {{DATA_WIDTH{1'b0}}, pe.a_in} * {{DATA_WIDTH{1'b0}}, pe.b_in};
    assign prod_ext = ACC_WIDTH'(prod_u);
  end

  acc_state_t           state;
  acc_state_t           state_nxt;
  logic                 first;
  logic                 done;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 acc_sat;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mac_fire && (K_DEPTH > 1)) state_nxt = RUN;
      RUN:  if (mac_fire && (cnt == CNT_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    first = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: begin
        first = mac_fire;
        done  = mac_fire && (K_DEPTH == 1);
      end
      RUN: begin
        done = mac_fire && (cnt == CNT_LAST);
      end
      default: begin
        first = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // the first product of a result starts from zero rather than whatever acc holds
  logic [ACC_WIDTH-1:0] acc_base;
  logic                 sat_base;
  sat_sum_t             sr;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 sum_sat;

  assign acc_base = first ? '0 : acc;
  assign sat_base = first ? 1'b0 : acc_sat;

  always_comb begin
    sr = sat_add(SAT_MAXW'(acc_base), SAT_MAXW'(prod_ext), ACC_WIDTH,
                 SIGNED != 0, SATURATE != 0);
  end

  assign acc_sum = ACC_WIDTH'(sr.sum);
  assign sum_sat = sat_base | (sr.overflow & (SATURATE != 0));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc     <= '0;
      cnt     <= '0;
      acc_sat <= 1'b0;
    end else if (mac_fire) begin
      if (done) begin
        acc     <= '0;
        cnt     <= '0;
        acc_sat <= 1'b0;
      end else begin
        acc     <= acc_sum;
        cnt     <= cnt + CNT_W'(1);
        acc_sat <= sum_sat;
      end
    end
  end

  pe_drain_slot #(
    .WIDTH(ACC_WIDTH)
  ) u_slot (
    .clock     (clock),
    .nreset    (nreset),
    .local_vld (done),
    .local_dat (acc_sum),
    .local_sat (sum_sat),
    .up_vld    (pe.res_valid_in),
    .up_dat    (pe.res_in),
    .up_sat    (pe.res_sat_in),
    .up_rdy    (pe.res_ready_out),
    .out_vld   (pe.res_valid_out),
    .out_dat   (pe.res_out),
    .out_sat   (pe.res_sat_out),
    .out_rdy   (pe.res_ready_in),
    .overrun   (pe.err_overrun)
  );

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Bench for systolic_pe_mac: narrow-width vector table, hand-written corner sequences,
// then randomized traffic on the wide PE against a behavioural model.
module tb_systolic_pe_mac;
  import systolic_pkg::*;

  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  systolic_pe_mac_if #(.DATA_WIDTH(16), .ACC_WIDTH(40)) if0 ();
  systolic_pe_mac_if #(.DATA_WIDTH(8),  .ACC_WIDTH(16)) if1 ();
  systolic_pe_mac_if #(.DATA_WIDTH(8),  .ACC_WIDTH(16)) if2 ();

  systolic_pe_mac #(.DATA_WIDTH(16), .ACC_WIDTH(40), .K_DEPTH(4), .SIGNED(1), .SATURATE(1))
    dut0 (.clock(clock), .nreset(nreset), .pe(if0.slave));
  systolic_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_DEPTH(4), .SIGNED(1), .SATURATE(1))
    dut1 (.clock(clock), .nreset(nreset), .pe(if1.slave));
  systolic_pe_mac #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_DEPTH(4), .SIGNED(1), .SATURATE(0))
    dut2 (.clock(clock), .nreset(nreset), .pe(if2.slave));

  assign if2.a_in         = if1.a_in;
  assign if2.a_valid_in   = if1.a_valid_in;
  assign if2.b_in         = if1.b_in;
  assign if2.b_valid_in   = if1.b_valid_in;
  assign if2.res_in       = if1.res_in;
  assign if2.res_sat_in   = if1.res_sat_in;
  assign if2.res_valid_in = if1.res_valid_in;
  assign if2.res_ready_in = if1.res_ready_in;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [15:0]     exp_sat;
    logic            exp_satf;
    logic [15:0]     exp_wrap;
  } vec_t;
  vec_t vt [6];

  // random-phase model state
  logic [15:0] ra, rb;
  logic        rav, rbv, rupv, rups, rrin;
  logic [39:0] rupd;
  logic [63:0] r64;
  longint      prods [$];
  longint      psum;
  bit          m_full, m_sat, m_err, local_c, exp_rdy, pop;
  logic [39:0] m_dat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv0(input logic [15:0] a, input logic av, input logic [15:0] b, input logic bv);
    if0.a_in       = a;
    if0.a_valid_in = av;
    if0.b_in       = b;
    if0.b_valid_in = bv;
  endtask

  task automatic macs0(input int n, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < n; i++) begin
      drv0(a, 1'b1, b, 1'b1);
      tick();
    end
    drv0(16'h0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    vt[0] = '{a: {4{8'h80}}, b: {4{8'h80}}, exp_sat: 16'h7fff, exp_satf: 1'b1, exp_wrap: 16'h0000};
    vt[1] = '{a: {4{8'h7f}}, b: {4{8'h7f}}, exp_sat: 16'h7fff, exp_satf: 1'b1, exp_wrap: 16'hfc04};
    vt[2] = '{a: {4{8'h80}}, b: {4{8'h7f}}, exp_sat: 16'h8000, exp_satf: 1'b1, exp_wrap: 16'h0200};
    vt[3] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
              exp_sat: 16'd70, exp_satf: 1'b0, exp_wrap: 16'd70};
    vt[4] = '{a: {8'hd8, 8'h1e, 8'hec, 8'h0a}, b: {4{8'd3}},
              exp_sat: 16'hffc4, exp_satf: 1'b0, exp_wrap: 16'hffc4};
    vt[5] = '{a: {8'h9c, 8'h9c, 8'h64, 8'h64}, b: {4{8'h64}},
              exp_sat: 16'h0000, exp_satf: 1'b0, exp_wrap: 16'h0000};

    nreset = 1'b0;
    drv0(16'h0, 1'b0, 16'h0, 1'b0);
    if0.res_in = '0; if0.res_sat_in = 1'b0; if0.res_valid_in = 1'b0; if0.res_ready_in = 1'b1;
    if1.a_in = '0; if1.a_valid_in = 1'b0; if1.b_in = '0; if1.b_valid_in = 1'b0;
    if1.res_in = '0; if1.res_sat_in = 1'b0; if1.res_valid_in = 1'b0; if1.res_ready_in = 1'b1;
    #12;
    check("rst a_out", if0.a_out, 0);
    check("rst res_valid", if0.res_valid_out, 0);
    check("rst res_out", if0.res_out, 0);
    check("rst err", if0.err_overrun, 0);
    check("rst state", dut0.state, IDLE);
    @(negedge clock);
    nreset = 1'b1;
    tick();

    // narrow PEs: saturating and wrapping copies see identical operands
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin
        if1.a_in = vt[k].a[i]; if1.b_in = vt[k].b[i];
        if1.a_valid_in = 1'b1; if1.b_valid_in = 1'b1;
        tick();
        if (i == 2) check($sformatf("vec%0d early valid", k), if1.res_valid_out, 0);
      end
      check($sformatf("vec%0d valid", k), if1.res_valid_out, 1);
      check($sformatf("vec%0d sat res", k), if1.res_out, vt[k].exp_sat);
      check($sformatf("vec%0d sat flag", k), if1.res_sat_out, vt[k].exp_satf);
      check($sformatf("vec%0d wrap res", k), if2.res_out, vt[k].exp_wrap);
      check($sformatf("vec%0d wrap flag", k), if2.res_sat_out, 0);
      if1.a_valid_in = 1'b0; if1.b_valid_in = 1'b0;
      tick();
      check($sformatf("vec%0d drained", k), if1.res_valid_out, 0);
    end

    // basic dot product with pass-through tracking
    for (int i = 0; i < 4; i++) begin
      drv0(16'(i + 1), 1'b1, 16'(i + 5), 1'b1);
      tick();
      check("pass a_out", if0.a_out, i + 1);
      check("pass b_out", if0.b_out, i + 5);
      check("pass a_valid", if0.a_valid_out, 1);
      if (i < 3) check("dot early valid", if0.res_valid_out, 0);
    end
    check("dot valid", if0.res_valid_out, 1);
    check("dot res", if0.res_out, 70);
    check("dot sat", if0.res_sat_out, 0);
    drv0(16'h55, 1'b0, 16'haa, 1'b0);
    tick();
    check("pass a_out novalid", if0.a_out, 16'h55);
    check("pass b_valid novalid", if0.b_valid_out, 0);
    check("dot popped", if0.res_valid_out, 0);

    // one-sided valids never fire a MAC
    for (int i = 0; i < 10; i++) begin
      drv0(16'd1, (i % 2) == 0, 16'd1, (i % 2) != 0);
      tick();
    end
    check("gap valid", if0.res_valid_out, 0);
    check("gap state", dut0.state, IDLE);
    macs0(4, 16'd1, 16'd1);
    check("gap res", if0.res_out, 4);
    check("gap res valid", if0.res_valid_out, 1);
    tick();

    // drain chain from upstream
    if0.res_valid_in = 1'b1; if0.res_in = 40'h123; if0.res_ready_in = 1'b1;
    tick();
    check("chain res", if0.res_out, 40'h123);
    check("chain valid", if0.res_valid_out, 1);
    if0.res_ready_in = 1'b0; if0.res_in = 40'h456;
    #1;
    check("chain rdy full", if0.res_ready_out, 0);
    tick();
    tick();
    check("chain hold", if0.res_out, 40'h123);
    if0.res_ready_in = 1'b1; if0.res_valid_in = 1'b0;
    tick();
    check("chain empty", if0.res_valid_out, 0);
    macs0(3, 16'd2, 16'd2);
    drv0(16'd2, 1'b1, 16'd2, 1'b1);
    if0.res_valid_in = 1'b1;
    #1;
    check("chain rdy local", if0.res_ready_out, 0);
    tick();
    check("chain local wins", if0.res_out, 16);
    drv0(16'h0, 1'b0, 16'h0, 1'b0);
    #1;
    check("chain rdy pop", if0.res_ready_out, 1);
    tick();
    check("chain upstream late", if0.res_out, 40'h456);
    if0.res_valid_in = 1'b0;
    tick();
    check("chain done", if0.res_valid_out, 0);

    // overrun: second local result finds the slot blocked
    if0.res_ready_in = 1'b0;
    macs0(4, 16'd3, 16'd3);
    check("ovr first", if0.res_out, 36);
    check("ovr err clear", if0.err_overrun, 0);
    macs0(4, 16'd5, 16'd5);
    check("ovr kept", if0.res_out, 36);
    check("ovr err set", if0.err_overrun, 1);
    if0.res_ready_in = 1'b1;
    tick();
    tick();
    check("ovr sticky", if0.err_overrun, 1);

    // reset mid-accumulation
    macs0(2, 16'd7, 16'd7);
    drv0(16'd7, 1'b0, 16'd7, 1'b0);
    nreset = 1'b0;
    #1;
    check("mid rst a_out", if0.a_out, 0);
    check("mid rst res_out", if0.res_out, 0);
    check("mid rst err", if0.err_overrun, 0);
    check("mid rst acc", dut0.acc, 0);
    @(negedge clock);
    nreset = 1'b1;
    tick();
    macs0(4, 16'd2, 16'd3);
    check("post rst res", if0.res_out, 24);
    check("post rst valid", if0.res_valid_out, 1);
    tick();

    // randomized traffic against the model
    m_full = 1'b0; m_sat = 1'b0; m_err = 1'b0; m_dat = '0;
    prods.delete();
    for (int c = 0; c < 800; c++) begin
      rav  = ($urandom_range(0, 9) < 8);
      rbv  = ($urandom_range(0, 9) < 8);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rupv = 1'($urandom_range(0, 1));
      rups = 1'($urandom_range(0, 1));
      r64  = {$urandom, $urandom};
      rupd = r64[39:0];
      rrin = ($urandom_range(0, 3) != 0);
      drv0(ra, rav, rb, rbv);
      if0.res_valid_in = rupv; if0.res_in = rupd; if0.res_sat_in = rups; if0.res_ready_in = rrin;
      local_c = rav && rbv && (prods.size() == 3);
      exp_rdy = (!m_full || rrin) && !local_c;
      @(negedge clock);
      check("rnd ready", if0.res_ready_out, exp_rdy);
      @(posedge clock);
      pop = m_full && rrin;
      if (rav && rbv) prods.push_back(longint'($signed(ra)) * longint'($signed(rb)));
      if (local_c) begin
        psum = 0;
        foreach (prods[j]) psum += prods[j];
        prods.delete();
        if (!m_full || pop) begin
          m_full = 1'b1; m_dat = psum[39:0]; m_sat = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end else if (rupv && exp_rdy) begin
        m_full = 1'b1; m_dat = rupd; m_sat = rups;
      end else if (pop) begin
        m_full = 1'b0;
      end
      #1;
      check("rnd valid", if0.res_valid_out, m_full);
      if (m_full) begin
        check("rnd res", if0.res_out, m_dat);
        check("rnd sat", if0.res_sat_out, m_sat);
      end
      check("rnd err", if0.err_overrun, m_err);
      check("rnd a_out", if0.a_out, ra);
      check("rnd b_valid", if0.b_valid_out, rbv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
